// File: rtl/mole_pkg.sv
// Shared types, widths and helpers for the whack-a-mole round controller.
// Also holds the mole-selection and saturating-score helpers.
package mole_pkg;

    localparam int              NUM_HOLES = 4;
    localparam int              SCORE_W   = 4;
    localparam logic [7:0]      LFSR_SEED = 8'hA5;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One-hot from the random select; bump to the next hole if it repeats the last mole
    function automatic logic [NUM_HOLES-1:0] pick_mole(
        input logic [1:0]           sel,
        input logic [NUM_HOLES-1:0] prev
    );
        logic [NUM_HOLES-1:0] cand;
        cand      = '0;
        cand[sel] = 1'b1;
        if (cand == prev) begin
            cand = {cand[NUM_HOLES-2:0], cand[NUM_HOLES-1]};
        end
        return cand;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + SCORE_ONE;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
        return (v == '0) ? v : v - SCORE_ONE;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, used to choose the lit hole.
module mole_lfsr
    import mole_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] out
);

    logic [7:0] lfsr_reg;
    logic       feedback;

    assign feedback = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], feedback};
        end
    end

    assign out = lfsr_reg;

endmodule

// File: rtl/mole_round_ctrl.sv
// Round controller: dark gap, lit window, scoring of hits/misses/cheats over a
// fixed number of rounds per game.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int WINDOW_CYC = 50,
    parameter int GAP_CYC    = 20,
    parameter int ROUNDS     = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] hit,
    output logic [NUM_HOLES-1:0] mole,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   misses,
    output logic                 busy,
    output logic                 game_over
);

    localparam int GAP_W = cnt_width(GAP_CYC);
    localparam int WIN_W = cnt_width(WINDOW_CYC);
    localparam int RND_W = cnt_width(ROUNDS + 1);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYC - 1);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

    state_t               state_reg, state_next;
    logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;
    logic [WIN_W-1:0]     win_cnt_reg, win_cnt_next;
    logic [RND_W-1:0]     round_cnt_reg, round_cnt_next;
    logic [SCORE_W-1:0]   score_reg, score_next;
    logic [SCORE_W-1:0]   misses_reg, misses_next;
    logic [NUM_HOLES-1:0] mole_reg, mole_next;
    logic [NUM_HOLES-1:0] prev_mole_reg, prev_mole_next;
    logic [NUM_HOLES-1:0] hit_q_reg;
    logic                 start_q_reg;

    logic [NUM_HOLES-1:0] hit_rise;
    logic                 start_rise;
    logic                 show_exit;
    logic [7:0]           lfsr_word;
    logic [5:0]           lfsr_unused;

    mole_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .out     (lfsr_word)
    );

    assign lfsr_unused = lfsr_word[7:2];

    for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_hit_edge
        assign hit_rise[gi] = hit[gi] & ~hit_q_reg[gi];
    end

    assign start_rise = start & ~start_q_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            gap_cnt_reg   <= '0;
            win_cnt_reg   <= '0;
            round_cnt_reg <= '0;
            score_reg     <= '0;
            misses_reg    <= '0;
            mole_reg      <= '0;
            prev_mole_reg <= '0;
            hit_q_reg     <= '0;
            // Treat start as already high so a level held through reset is not an edge
            start_q_reg   <= 1'b1;
        end else begin
            state_reg     <= state_next;
            gap_cnt_reg   <= gap_cnt_next;
            win_cnt_reg   <= win_cnt_next;
            round_cnt_reg <= round_cnt_next;
            score_reg     <= score_next;
            misses_reg    <= misses_next;
            mole_reg      <= mole_next;
            prev_mole_reg <= prev_mole_next;
            hit_q_reg     <= hit;
            start_q_reg   <= start;
        end
    end

    always_comb begin
        state_next     = state_reg;
        gap_cnt_next   = gap_cnt_reg;
        win_cnt_next   = win_cnt_reg;
        round_cnt_next = round_cnt_reg;
        score_next     = score_reg;
        misses_next    = misses_reg;
        mole_next      = mole_reg;
        prev_mole_next = prev_mole_reg;
        show_exit      = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_rise) begin
                    state_next     = ST_GAP;
                    gap_cnt_next   = '0;
                    round_cnt_next = '0;
                    score_next     = '0;
                    misses_next    = '0;
                end
            end

            ST_GAP: begin
                // Pressing while dark is a cheat and restarts the gap, even on its last cycle
                if (|hit_rise) begin
                    score_next   = sat_dec(score_reg);
                    gap_cnt_next = '0;
                end else if (gap_cnt_reg == GAP_LAST) begin
                    state_next     = ST_SHOW;
                    win_cnt_next   = '0;
                    mole_next      = pick_mole(lfsr_word[1:0], prev_mole_reg);
                    prev_mole_next = mole_next;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end

            ST_SHOW: begin
                // A hit is checked before the timeout so a final-cycle press still scores
                if (|hit_rise) begin
                    show_exit = 1'b1;
                    if (|(hit_rise & ~mole_reg)) begin
                        misses_next = sat_inc(misses_reg);
                        score_next  = sat_dec(score_reg);
                    end else begin
                        score_next  = sat_inc(score_reg);
                    end
                end else if (win_cnt_reg == WIN_LAST) begin
                    show_exit   = 1'b1;
                    misses_next = sat_inc(misses_reg);
                end else begin
                    win_cnt_next = win_cnt_reg + WIN_W'(1);
                end

                if (show_exit) begin
                    mole_next      = '0;
                    gap_cnt_next   = '0;
                    round_cnt_next = round_cnt_reg + RND_W'(1);
                    state_next     = (round_cnt_reg == RND_LAST) ? ST_DONE : ST_GAP;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mole      = mole_reg;
    assign score     = score_reg;
    assign misses    = misses_reg;
    assign busy      = (state_reg == ST_GAP) || (state_reg == ST_SHOW);
    assign game_over = (state_reg == ST_DONE);

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl: a game-level reference model checked every
// cycle, plus literal end-of-scenario expectations.
module tb_mole_round_ctrl;

    localparam int WIN = 50;
    localparam int GAP = 20;
    localparam int RND = 10;

    localparam int PH_IDLE = 0;
    localparam int PH_GAP  = 1;
    localparam int PH_SHOW = 2;
    localparam int PH_DONE = 3;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] hit     = 4'b0000;
    logic [3:0] mole;
    logic [3:0] score;
    logic [3:0] misses;
    logic       busy;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    mole_round_ctrl #(
        .WINDOW_CYC (WIN),
        .GAP_CYC    (GAP),
        .ROUNDS     (RND)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .hit       (hit),
        .mole      (mole),
        .score     (score),
        .misses    (misses),
        .busy      (busy),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- game-level reference model ----------------
    int         m_phase      = PH_IDLE;
    int         m_left       = 0;
    int         m_round      = 0;
    int         m_score      = 0;
    int         m_misses     = 0;
    logic [3:0] m_mole       = 4'b0000;
    logic [3:0] m_last       = 4'b0000;
    logic [3:0] m_hit_prev   = 4'b0000;
    logic       m_start_prev = 1'b1;
    logic [7:0] m_lfsr       = 8'hA5;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    initial begin
        forever begin
            logic [3:0] rise;
            logic       srise;
            logic       fin;
            int         idx;
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_phase = PH_IDLE; m_left = 0; m_round = 0; m_score = 0; m_misses = 0;
                m_mole = 4'b0000; m_last = 4'b0000; m_hit_prev = 4'b0000;
                m_start_prev = 1'b1; m_lfsr = 8'hA5;
            end else begin
                rise  = hit & ~m_hit_prev;
                srise = start && !m_start_prev;
                fin   = 1'b0;
                case (m_phase)
                    PH_IDLE, PH_DONE: begin
                        if (srise) begin
                            m_score = 0; m_misses = 0; m_round = 0;
                            m_phase = PH_GAP; m_left = GAP;
                        end
                    end
                    PH_GAP: begin
                        if (rise != 4'b0000) begin
                            if (m_score > 0) m_score--;
                            m_left = GAP;
                        end else if (m_left == 1) begin
                            idx = int'(m_lfsr % 8'd4);
                            if (4'(4'b0001 << idx) == m_last) idx = (idx + 1) % 4;
                            m_mole  = 4'(4'b0001 << idx);
                            m_last  = m_mole;
                            m_phase = PH_SHOW;
                            m_left  = WIN;
                        end else begin
                            m_left--;
                        end
                    end
                    default: begin
                        if (rise != 4'b0000) begin
                            fin = 1'b1;
                            if ((rise & ~m_mole) != 4'b0000) begin
                                if (m_misses < 15) m_misses++;
                                if (m_score > 0) m_score--;
                            end else if (m_score < 15) begin
                                m_score++;
                            end
                        end else if (m_left == 1) begin
                            fin = 1'b1;
                            if (m_misses < 15) m_misses++;
                        end else begin
                            m_left--;
                        end
                        if (fin) begin
                            m_mole  = 4'b0000;
                            m_round++;
                            m_phase = (m_round == RND) ? PH_DONE : PH_GAP;
                            m_left  = GAP;
                        end
                    end
                endcase
                m_hit_prev   = hit;
                m_start_prev = start;
                m_lfsr       = lfsr_step(m_lfsr);
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("cycle_outputs",
                  {18'd0, mole, score, misses, busy, game_over},
                  {18'd0, m_mole, 4'(m_score), 4'(m_misses),
                   (m_phase == PH_GAP) || (m_phase == PH_SHOW), m_phase == PH_DONE});
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [3:0] last_lit = 4'b0000;
    int         round_no = 0;

    task automatic wait_lit(output logic [3:0] lit);
        logic found;
        found = 1'b0;
        lit   = 4'b0000;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (mole != 4'b0000) begin
                lit   = mole;
                found = 1'b1;
            end
        end
        if (!found) begin
            check("wait_lit_timeout", 32'd0, 32'd1);
        end else begin
            check("mole_onehot", 32'($onehot(lit)), 32'd1);
            check("mole_differs", 32'(lit != last_lit), 32'd1);
            last_lit = lit;
        end
    endtask

    task automatic press_at(input int cyc, input logic [3:0] pattern);
        repeat (cyc - 1) @(posedge clk);
        #1 hit = pattern;
        @(posedge clk);
        #1 hit = 4'b0000;
    endtask

    // kind: 0 lit button at cycle 3, 1 lit+neighbour, 2 neighbour only, 3 lit button at last cycle
    task automatic play_round(input int kind);
        logic [3:0] lit;
        logic [3:0] other;
        wait_lit(lit);
        other = {lit[2:0], lit[3]};
        case (kind)
            0:       press_at(3, lit);
            1:       press_at(3, lit | other);
            2:       press_at(3, other);
            default: press_at(WIN, lit);
        endcase
        @(negedge clk);
        round_no++;
        $display("round %0d kind=%0d lit=%b score=%0d misses=%0d", round_no, kind, lit, score, misses);
    endtask

    task automatic count_lit(output int n);
        logic [3:0] lit;
        logic       gone;
        wait_lit(lit);
        n    = 1;
        gone = 1'b0;
        for (int i = 0; i < 100 && !gone; i++) begin
            @(negedge clk);
            if (mole == 4'b0000) gone = 1'b1;
            else n++;
        end
        round_no++;
        $display("round %0d timeout lit=%b lit_cycles=%0d misses=%0d", round_no, lit, n, misses);
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (game_over) seen = 1'b1;
        end
        if (!seen) check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_game();
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        round_no = 0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int         n;
        logic       gone;
        logic       lit_seen;
        logic [3:0] lit;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {18'd0, mole, score, misses, busy, game_over}, 32'd0);
        #2 reset_n = 1'b1;

        // Perfect game
        start_game();
        for (int r = 0; r < RND; r++) play_round(0);
        wait_done();
        check("perfect_score", 32'(score), 32'd10);
        check("perfect_misses", 32'(misses), 32'd0);
        check("perfect_game_over", 32'(game_over), 32'd1);
        check("perfect_mole", 32'(mole), 32'd0);

        // Never press: every window times out
        start_game();
        for (int r = 0; r < RND; r++) begin
            count_lit(n);
            check("timeout_show_len", n, WIN);
        end
        wait_done();
        check("timeout_score", 32'(score), 32'd0);
        check("timeout_misses", 32'(misses), 32'd10);
        check("timeout_game_over", 32'(game_over), 32'd1);

        // Mixed game: multi-press, wrong press, cheat, held button, last-cycle hit
        start_game();
        play_round(0);
        play_round(0);
        check("pre_multi_score", 32'(score), 32'd2);
        play_round(1);
        check("multi_misses", 32'(misses), 32'd1);
        check("multi_score", 32'(score), 32'd1);
        check("multi_back_to_gap", {26'd0, busy, game_over, mole}, 32'b10_0000);
        play_round(2);
        check("wrong_score", 32'(score), 32'd0);
        check("wrong_misses", 32'(misses), 32'd2);

        repeat (5) @(posedge clk);
        #1 hit = 4'b0001;
        @(posedge clk);
        n        = 0;
        lit_seen = 1'b0;
        for (int i = 0; i < 200 && !lit_seen; i++) begin
            @(negedge clk);
            if (mole != 4'b0000) lit_seen = 1'b1;
            else n++;
        end
        check("cheat_score_floor", 32'(score), 32'd0);
        check("cheat_gap_len", n, GAP);
        lit = mole;
        check("held_mole_differs", 32'(lit != last_lit), 32'd1);
        last_lit = lit;
        n    = 1;
        gone = 1'b0;
        for (int i = 0; i < 100 && !gone; i++) begin
            @(negedge clk);
            if (mole == 4'b0000) gone = 1'b1;
            else n++;
        end
        $display("held-button round lit=%b lit_cycles=%0d score=%0d misses=%0d", lit, n, score, misses);
        check("held_show_len", n, WIN);
        check("held_score", 32'(score), 32'd0);
        check("held_misses", 32'(misses), 32'd3);
        @(posedge clk);
        #1 hit = 4'b0000;

        play_round(3);
        check("last_cycle_hit_score", 32'(score), 32'd1);
        check("last_cycle_hit_misses", 32'(misses), 32'd3);
        for (int r = 0; r < 4; r++) play_round(0);
        wait_done();
        check("mixed_score", 32'(score), 32'd5);
        check("mixed_misses", 32'(misses), 32'd3);
        check("mixed_game_over", 32'(game_over), 32'd1);

        // Reset in the middle of a lit window, start held high across release
        start_game();
        wait_lit(lit);
        repeat (10) @(negedge clk);
        start = 1'b1;
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", {18'd0, mole, score, misses, busy, game_over}, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        last_lit = 4'b0000;
        repeat (30) @(negedge clk);
        check("no_restart_while_held", {18'd0, mole, score, misses, busy, game_over}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("restart_on_new_edge", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
